// File: rtl/gpia_wide.sv
// gpia_wide: parametrised Wishbone-style general-purpose I/O adapter.
//   - WIDTH output bits (with atomic set/clear) and WIDTH synchronised input bits.
//   - Two-cycle bus access: ACK_O and DAT_O are registered.
//   - Optional per-bit edge-detect interrupts, built only when the macro
//     GPIA_WIDE_IRQ_EN is defined. Without it, registers 4-6 read 0 and
//     IRQ_O is tied low.
//
// Register map (ADR_I):
//   0 IN    synchronised inputs (read-only)
//   1 OUT   output register
//   2 SET   write: OUT |= DAT_I, read: OUT
//   3 CLR   write: OUT &= ~DAT_I, read: OUT
//   4 MASK  interrupt mask
//   5 PEND  interrupt pending, write 1 to clear
//   6 EDGE  edge select per bit, 1 = rising, 0 = falling
//   7 --    reserved, reads 0
module gpia_wide #(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  output logic [WIDTH-1:0] PORT_O,
  input  logic [WIDTH-1:0] PORT_I,
  input  logic [2:0]       ADR_I,
  input  logic             CYC_I,
  input  logic             STB_I,
  input  logic             WE_I,
  input  logic [WIDTH-1:0] DAT_I,
  output logic [WIDTH-1:0] DAT_O,
  output logic             ACK_O,
  output logic             IRQ_O
);

  localparam logic [2:0] ADR_IN   = 3'd0;
  localparam logic [2:0] ADR_OUT  = 3'd1;
  localparam logic [2:0] ADR_SET  = 3'd2;
  localparam logic [2:0] ADR_CLR  = 3'd3;
  localparam logic [2:0] ADR_MASK = 3'd4;
  localparam logic [2:0] ADR_PEND = 3'd5;
  localparam logic [2:0] ADR_EDGE = 3'd6;

  logic             r_ack;
  logic [WIDTH-1:0] r_dat;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];

  logic             w_acc;
  logic             w_wr;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_rdata;

  // The access completes on the edge that raises ACK; ACK then blocks a
  // second completion on the following edge, so a held strobe completes
  // every second cycle.
  assign w_acc = CYC_I & STB_I & ~r_ack;
  assign w_wr  = w_acc & WE_I;
  assign w_s   = r_sync[SYNC_STAGES-1];

  assign PORT_O = r_out;
  assign DAT_O  = r_dat;
  assign ACK_O  = r_ack;

  // Input synchroniser chain; only the last stage is used anywhere.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= PORT_I;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Output register with plain write and atomic set/clear.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_out <= OUT_RESET;
    end else if (w_wr) begin
      case (ADR_I)
        ADR_OUT: r_out <= DAT_I;
        ADR_SET: r_out <= r_out | DAT_I;
        ADR_CLR: r_out <= r_out & ~DAT_I;
        default: r_out <= r_out;
      endcase
    end
  end

`ifdef GPIA_WIDE_IRQ_EN
  // Arming waits long enough for the synchroniser and the previous-sample
  // register to hold real input values, so inputs already high at reset
  // release are not mistaken for edges.
  localparam logic [2:0] ARM_TC = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_pend;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] r_prev;
  logic [2:0]       r_arm;
  logic             r_irq;

  logic             w_armed;
  logic [WIDTH-1:0] w_hit;
  logic [WIDTH-1:0] w_w1c;

  assign w_armed = (r_arm == ARM_TC);
  assign w_hit   = w_armed ? ((r_edge & w_s & ~r_prev) | (~r_edge & ~w_s & r_prev))
                           : '0;
  assign w_w1c   = (w_wr && ADR_I == ADR_PEND) ? DAT_I : '0;
  assign IRQ_O   = r_irq;

  // Saturating arm counter.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_arm <= '0;
    end else if (!w_armed) begin
      r_arm <= r_arm + 3'd1;
    end
  end

  // Previous sample tracks the synchroniser output even while unarmed.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_prev <= '0;
    end else begin
      r_prev <= w_s;
    end
  end

  // Mask and edge-select registers.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_mask <= '0;
      r_edge <= '1;
    end else if (w_wr) begin
      if (ADR_I == ADR_MASK) r_mask <= DAT_I;
      if (ADR_I == ADR_EDGE) r_edge <= DAT_I;
    end
  end

  // Pending: a new hit wins over a simultaneous write-1-to-clear.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_w1c) | w_hit;
    end
  end

  // Registered level interrupt.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_pend & r_mask);
    end
  end
`else
  assign IRQ_O = 1'b0;
`endif

  // Read-data selection for the current address.
  always_comb begin
    w_rdata = '0;
    case (ADR_I)
      ADR_IN:   w_rdata = w_s;
      ADR_OUT:  w_rdata = r_out;
      ADR_SET:  w_rdata = r_out;
      ADR_CLR:  w_rdata = r_out;
`ifdef GPIA_WIDE_IRQ_EN
      ADR_MASK: w_rdata = r_mask;
      ADR_PEND: w_rdata = r_pend;
      ADR_EDGE: w_rdata = r_edge;
`endif
      default:  w_rdata = '0;
    endcase
  end

  // Bus acknowledge and read data; writes and idle cycles return zero.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= (w_acc && !WE_I) ? w_rdata : '0;
    end
  end

endmodule
